pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the 3-stage MIPS core, generalising the fixed-field ID/EX latch.
- Carries an opaque data bundle, a control bundle and exception flags between any two stages.
- Uses a valid/ready handshake, with an optional skid entry so ready can be registered.
- Supports synchronous flush that injects bubbles with a defined control reset pattern, plus a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with optional skid entry, flush and stall counter
module pipe_stage_reg #(
  parameter int                DATA_W   = 96,
  parameter int                CTRL_W   = 24,
  parameter int                EXC_W    = 2,
  parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}},
  parameter logic [EXC_W-1:0]  EXC_RST  = {EXC_W{1'b0}},
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [EXC_W-1:0]  in_excp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [EXC_W-1:0]  out_excp,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stateT;

  stateT state, stateNext;

  logic              mValid, sValid;
  logic              acc, drn;
  logic              loadMIn, loadMSkid, loadS;
  logic [1:0]        occNext, occReg;
  logic [DATA_W-1:0] mData, sData;
  logic [CTRL_W-1:0] mCtrl, sCtrl;
  logic [EXC_W-1:0]  mExcp, sExcp;
  logic [CNT_W-1:0]  stallCnt;

  assign mValid = (state != EMPTY);
  assign sValid = (state == FULL);

  // With a skid entry, ready depends only on state flops, cutting the out_ready path.
  generate
    if (SKID != 0) begin : gSkid
      assign in_ready = !sValid;
    end else begin : gSingle
      assign in_ready = out_ready || !mValid;
    end
  endgenerate

  assign acc = in_valid && in_ready;
  assign drn = mValid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    loadMIn   = 1'b0;
    loadMSkid = 1'b0;
    loadS     = 1'b0;
    if (!flush) begin
      case (state)
        EMPTY: begin
          if (acc) begin
            stateNext = ONE;
            loadMIn   = 1'b1;
          end
        end
        ONE: begin
          if (acc && drn) begin
            loadMIn = 1'b1;
          end else if (acc && (SKID != 0)) begin
            stateNext = FULL;
            loadS     = 1'b1;
          end else if (drn) begin
            stateNext = EMPTY;
          end
        end
        FULL: begin
          if (drn) begin
            stateNext = ONE;
            loadMSkid = 1'b1;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end else begin
      stateNext = EMPTY;
    end
    occNext = {1'b0, (stateNext != EMPTY)} + {1'b0, (stateNext == FULL)};
  end

  // Data is not cleared on flush; only the valid bits drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      mData <= '0;
      mCtrl <= CTRL_RST;
      mExcp <= EXC_RST;
      sData <= '0;
      sCtrl <= CTRL_RST;
      sExcp <= EXC_RST;
    end else begin
      if (loadMIn) begin
        mData <= in_data;
        mCtrl <= in_ctrl;
        mExcp <= in_excp;
      end else if (loadMSkid) begin
        mData <= sData;
        mCtrl <= sCtrl;
        mExcp <= sExcp;
      end
      if (loadS) begin
        sData <= in_data;
        sCtrl <= in_ctrl;
        sExcp <= in_excp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occReg <= 2'd0;
    end else begin
      occReg <= occNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (mValid && !out_ready && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign out_valid = mValid;
  assign out_data  = mData;
  assign out_ctrl  = mValid ? mCtrl : CTRL_RST;
  assign out_excp  = mValid ? mExcp : EXC_RST;
  assign occupancy = occReg;
  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg against a FIFO model
module tb_pipe_stage_reg;

  localparam logic [23:0] CRST1 = 24'hC0FFEE;
  localparam logic [1:0]  ERST1 = 2'b10;

  logic        clk = 1'b0;
  logic        reset, inValid, outReady, flush;
  logic [95:0] inData;
  logic [23:0] inCtrl;
  logic [1:0]  inExcp;

  logic        inReady0, outValid0, inReady1, outValid1;
  logic [95:0] outData0, outData1;
  logic [23:0] outCtrl0, outCtrl1;
  logic [1:0]  outExcp0, outExcp1, occ0, occ1;
  logic [3:0]  stall0, stall1;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady0),
    .in_data(inData), .in_ctrl(inCtrl), .in_excp(inExcp),
    .out_valid(outValid0), .out_ready(outReady), .out_data(outData0),
    .out_ctrl(outCtrl0), .out_excp(outExcp0), .flush(flush),
    .occupancy(occ0), .stall_cnt(stall0)
  );

  pipe_stage_reg #(.SKID(1), .CNT_W(4), .CTRL_RST(CRST1), .EXC_RST(ERST1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady1),
    .in_data(inData), .in_ctrl(inCtrl), .in_excp(inExcp),
    .out_valid(outValid1), .out_ready(outReady), .out_data(outData1),
    .out_ctrl(outCtrl1), .out_excp(outExcp1), .flush(flush),
    .occupancy(occ1), .stall_cnt(stall1)
  );

  typedef struct packed {
    logic [95:0] d;
    logic [23:0] c;
    logic [1:0]  e;
  } entT;

  entT         fifo [2][2];
  int          cnt [2];
  int          stl [2];
  logic [95:0] shown [2];
  bit          checkEn = 1'b0;
  int          nChecks = 0;
  int          nFail = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a FIFO of capacity 2 (skid) or 1, holding the last front data when empty.
  task automatic modelStep(int k);
    bit rdy, acc, drn;
    rdy = (k == 1) ? (cnt[k] < 2) : (outReady || cnt[k] == 0);
    acc = inValid && rdy;
    drn = (cnt[k] > 0) && outReady;
    if (reset) begin
      cnt[k] = 0;
      stl[k] = 0;
      shown[k] = '0;
    end else begin
      if (cnt[k] > 0 && !outReady && stl[k] < 15) stl[k]++;
      if (flush) begin
        cnt[k] = 0;
      end else begin
        if (drn) begin
          fifo[k][0] = fifo[k][1];
          cnt[k]--;
        end
        if (acc) begin
          fifo[k][cnt[k]] = {inData, inCtrl, inExcp};
          cnt[k]++;
        end
        if (cnt[k] > 0) shown[k] = fifo[k][0].d;
      end
    end
  endtask

  task automatic checkDut(int k, logic ir, logic ov, logic [95:0] od, logic [23:0] oc,
                          logic [1:0] oe, logic [1:0] oc2, logic [3:0] st);
    logic [23:0] crst;
    logic [1:0]  erst;
    logic        expIr;
    crst  = (k == 1) ? CRST1 : 24'h0;
    erst  = (k == 1) ? ERST1 : 2'b00;
    expIr = (k == 1) ? (cnt[k] < 2) : (outReady || cnt[k] == 0);
    check($sformatf("dut%0d.in_ready", k), ir, expIr);
    check($sformatf("dut%0d.out_valid", k), ov, cnt[k] > 0);
    check($sformatf("dut%0d.out_data", k), od, shown[k]);
    check($sformatf("dut%0d.out_ctrl", k), oc, (cnt[k] > 0) ? fifo[k][0].c : crst);
    check($sformatf("dut%0d.out_excp", k), oe, (cnt[k] > 0) ? fifo[k][0].e : erst);
    check($sformatf("dut%0d.occupancy", k), oc2, cnt[k]);
    check($sformatf("dut%0d.stall_cnt", k), st, stl[k]);
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkDut(0, inReady0, outValid0, outData0, outCtrl0, outExcp0, occ0, stall0);
      checkDut(1, inReady1, outValid1, outData1, outCtrl1, outExcp1, occ1, stall1);
    end
  end

  task automatic step();
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    if (reset) checkEn = 1'b1;
    #1;
  endtask

  task automatic push(logic [95:0] d);
    inValid = 1'b1;
    inData  = d;
    step();
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b1; inCtrl = 24'hFFFFFF; inExcp = 2'b11;
    inData = 96'h123; outReady = 1'b0; flush = 1'b0;
    step();
    step();
    reset = 1'b0; inValid = 1'b0;
    check("rst.out_valid", outValid1, 1'b0);
    check("rst.out_ctrl", outCtrl1, CRST1);
    check("rst.out_excp", outExcp1, ERST1);
    check("rst.out_data", outData1, 96'h0);
    check("rst.stall_cnt", stall1, 4'd0);
    check("rst.in_ready", inReady1, 1'b1);

    // Streaming at full rate
    outReady = 1'b1; inCtrl = 24'h00A5A5; inExcp = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      push(96'(i));
      check("stream.out_data1", outData1, 96'(i));
      check("stream.out_data0", outData0, 96'(i));
      check("stream.occ1", occ1, 2'd1);
      check("stream.out_ctrl1", outCtrl1, 24'h00A5A5);
    end
    inValid = 1'b0;
    step();
    check("stream.drained", outValid1, 1'b0);

    // Backpressure: A held, B in skid, C held upstream
    outReady = 1'b0;
    push(96'hA);
    check("bp.A_out", outData1, 96'hA);
    check("bp.ready_after_A", inReady1, 1'b1);
    push(96'hB);
    check("bp.occ_full", occ1, 2'd2);
    check("bp.ready_after_B", inReady1, 1'b0);
    push(96'hC);
    push(96'hC);
    check("bp.A_held", outData1, 96'hA);
    check("bp.stall_cnt", stall1, 4'd3);
    outReady = 1'b1;
    step();
    check("bp.B_out", outData1, 96'hB);
    step();
    check("bp.C_out", outData1, 96'hC);
    check("bp.C_valid", outValid1, 1'b1);
    inValid = 1'b0;
    step();
    check("bp.empty", outValid1, 1'b0);
    check("bp.stall_kept", stall1, 4'd3);

    // Flush while full: D is dropped, E flows normally
    outReady = 1'b0;
    push(96'hD1);
    push(96'hD2);
    check("fl.occ_before", occ1, 2'd2);
    flush = 1'b1;
    push(96'hDD);
    flush = 1'b0; inValid = 1'b0;
    check("fl.occ_after", occ1, 2'd0);
    check("fl.out_valid", outValid1, 1'b0);
    check("fl.out_ctrl", outCtrl1, CRST1);
    check("fl.data_kept", outData1, 96'hD1);
    outReady = 1'b1;
    push(96'hEE);
    check("fl.E_out", outData1, 96'hEE);
    inValid = 1'b0;
    step();
    check("fl.no_D", outData1, 96'hEE);

    // Stall counter saturation
    outReady = 1'b0;
    inValid = 1'b1;
    repeat (20) step();
    check("sat.stall1", stall1, 4'd15);
    check("sat.stall0", stall0, 4'd15);
    repeat (3) step();
    check("sat.hold", stall1, 4'd15);
    reset = 1'b1;
    step();
    reset = 1'b0; inValid = 1'b0;
    check("sat.rst1", stall1, 4'd0);
    check("sat.rst0", stall0, 4'd0);

    // Single-entry variant: ready follows out_ready while full
    outReady = 1'b1;
    push(96'h51);
    outReady = 1'b0;
    #1;
    check("s0.ready_low", inReady0, 1'b0);
    outReady = 1'b1;
    #1;
    check("s0.ready_high", inReady0, 1'b1);
    push(96'h52);
    check("s0.next", outData0, 96'h52);
    for (int i = 0; i < 12; i++) begin
      outReady = (i % 3) != 1;
      push(96'h60 + 96'(i));
      check("s0.occ_max", occ0 <= 2'd1, 1'b1);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      inValid  = ($urandom % 4) != 0;
      outReady = (i % 200 < 40) ? (($urandom % 8) == 0) : (($urandom % 3) != 0);
      flush    = ($urandom % 32) == 0;
      reset    = ($urandom % 500) == 0;
      inData   = {32'(i), $urandom, $urandom};
      inCtrl   = 24'($urandom);
      inExcp   = 2'($urandom);
      step();
    end
    reset = 1'b0; flush = 1'b0; inValid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
